// File: rtl/tlb_lookup_ctrl_pkg.sv
// tlb_lookup_ctrl_pkg: shared geometry, permission bits and FSM encodings for the TLB lookup controller
package tlb_lookup_ctrl_pkg;
  localparam int NUM_SETS = 16;
  localparam int NUM_WAYS = 4;
  localparam int WAY_BITS = 2;
  localparam int SET_INDEX_BITS = 4;
  localparam int LRU_BITS = 4;
  localparam int PAGE_OFFSET_BITS = 12;
  localparam int VPN_BITS = 20;
  localparam int PERM_R = 0;
  localparam int PERM_W = 1;
  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_LOOKUP = 3'd1;
  localparam logic [2:0] S_PTW_REQ = 3'd2;
  localparam logic [2:0] S_PTW_WAIT = 3'd3;
  localparam logic [2:0] S_FILL = 3'd4;
  localparam logic [2:0] S_RESP = 3'd5;
  function automatic logic perm_ok(input logic [1:0] perms, input logic is_write);
    return is_write ? perms[PERM_W] : perms[PERM_R];
  endfunction
endpackage

// File: rtl/tlb_lookup_ctrl_victim_select.sv
// tlb_victim_select: lowest invalid way, else least-used way with ties to the lowest index
module tlb_victim_select
  import tlb_lookup_ctrl_pkg::*;
(
  input  logic [NUM_WAYS-1:0]          rd_valid,
  input  logic [NUM_WAYS*LRU_BITS-1:0] rd_lru_count,
  output logic [WAY_BITS-1:0]          victim
);
  logic [WAY_BITS-1:0] inv_way, lru_way;
  logic [LRU_BITS-1:0] min_cnt;
  always_comb begin
    inv_way = '0;
    for (int w = NUM_WAYS - 1; w >= 0; w--)
      if (!rd_valid[w]) inv_way = WAY_BITS'(w);
    lru_way = '0;
    min_cnt = rd_lru_count[LRU_BITS-1:0];
    for (int w = 1; w < NUM_WAYS; w++)
      if (rd_lru_count[w*LRU_BITS +: LRU_BITS] < min_cnt) begin
        min_cnt = rd_lru_count[w*LRU_BITS +: LRU_BITS];
        lru_way = WAY_BITS'(w);
      end
  end
  assign victim = &rd_valid ? lru_way : inv_way;
endmodule

// File: rtl/tlb_lookup_ctrl.sv
// tlb_lookup_ctrl: TLB lookup controller; hit compare, LRU bump, page-walk on miss, fill and response
module tlb_lookup_ctrl
  import tlb_lookup_ctrl_pkg::*;
(
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          req_valid,
  output logic                          req_ready,
  input  logic [31:0]                   req_vaddr,
  input  logic                          req_is_write,
  output logic                          resp_valid,
  input  logic                          resp_ready,
  output logic [31:0]                   resp_paddr,
  output logic                          resp_hit,
  output logic                          resp_fault,
  output logic [SET_INDEX_BITS-1:0]     rd_set_index,
  input  logic [NUM_WAYS-1:0]           rd_valid,
  input  logic [NUM_WAYS*VPN_BITS-1:0]  rd_vpn,
  input  logic [NUM_WAYS*VPN_BITS-1:0]  rd_ppn,
  input  logic [NUM_WAYS*2-1:0]         rd_perms,
  input  logic [NUM_WAYS*LRU_BITS-1:0]  rd_lru_count,
  output logic                          wr_en,
  output logic [SET_INDEX_BITS-1:0]     wr_set_index,
  output logic [1:0]                    wr_way,
  output logic                          wr_valid,
  output logic [19:0]                   wr_vpn,
  output logic [19:0]                   wr_ppn,
  output logic [1:0]                    wr_perms,
  output logic [LRU_BITS-1:0]           wr_lru_count,
  output logic                          lru_update_en,
  output logic [SET_INDEX_BITS-1:0]     lru_set_index,
  output logic [1:0]                    lru_way,
  output logic                          ptw_req_valid,
  input  logic                          ptw_req_ready,
  output logic [19:0]                   ptw_req_vpn,
  input  logic                          ptw_resp_valid,
  input  logic [19:0]                   ptw_resp_ppn,
  input  logic [1:0]                    ptw_resp_perms,
  input  logic                          ptw_resp_fault,
  output logic [31:0]                   stat_hits,
  output logic [31:0]                   stat_misses
);
  logic [2:0] state_q, state_d;
  logic [31:0] vaddr_q, vaddr_d;
  logic is_write_q, is_write_d;
  logic [VPN_BITS-1:0] ppn_q, ppn_d;
  logic [1:0] perms_q, perms_d;
  logic hit_q, hit_d, fault_q, fault_d;
  logic [31:0] hits_q, hits_d, misses_q, misses_d;
  logic [VPN_BITS-1:0] vpn, hit_ppn;
  logic [1:0] hit_perms;
  logic [SET_INDEX_BITS-1:0] set_idx;
  logic lk_hit;
  logic [WAY_BITS-1:0] lk_way, victim;
  assign vpn = vaddr_q[31:PAGE_OFFSET_BITS];
  assign set_idx = vpn[SET_INDEX_BITS-1:0];
  assign hit_ppn = rd_ppn[lk_way*VPN_BITS +: VPN_BITS];
  assign hit_perms = rd_perms[lk_way*2 +: 2];
  // Descending scan so the lowest matching way is the last one written
  always_comb begin
    lk_hit = 1'b0;
    lk_way = '0;
    for (int w = NUM_WAYS - 1; w >= 0; w--)
      if (rd_valid[w] && rd_vpn[w*VPN_BITS +: VPN_BITS] == vpn) begin
        lk_hit = 1'b1;
        lk_way = WAY_BITS'(w);
      end
  end
  tlb_victim_select u_victim (
    .rd_valid     (rd_valid),
    .rd_lru_count (rd_lru_count),
    .victim       (victim)
  );
  always_comb begin
    state_d = state_q;
    vaddr_d = vaddr_q;
    is_write_d = is_write_q;
    ppn_d = ppn_q;
    perms_d = perms_q;
    hit_d = hit_q;
    fault_d = fault_q;
    hits_d = hits_q;
    misses_d = misses_q;
    case (state_q)
      S_IDLE: if (req_valid) begin
        vaddr_d = req_vaddr;
        is_write_d = req_is_write;
        state_d = S_LOOKUP;
      end
      S_LOOKUP: if (lk_hit) begin
        hit_d = 1'b1;
        ppn_d = hit_ppn;
        perms_d = hit_perms;
        fault_d = !perm_ok(hit_perms, is_write_q);
        hits_d = hits_q + 32'd1;
        state_d = S_RESP;
      end else begin
        hit_d = 1'b0;
        misses_d = misses_q + 32'd1;
        state_d = S_PTW_REQ;
      end
      S_PTW_REQ: if (ptw_req_ready) state_d = S_PTW_WAIT;
      S_PTW_WAIT: if (ptw_resp_valid) begin
        ppn_d = ptw_resp_ppn;
        perms_d = ptw_resp_perms;
        fault_d = ptw_resp_fault || !perm_ok(ptw_resp_perms, is_write_q);
        state_d = ptw_resp_fault ? S_RESP : S_FILL;
      end
      S_FILL: state_d = S_RESP;
      S_RESP: if (resp_ready) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state_q <= S_IDLE;
      vaddr_q <= '0;
      is_write_q <= 1'b0;
      ppn_q <= '0;
      perms_q <= '0;
      hit_q <= 1'b0;
      fault_q <= 1'b0;
      hits_q <= '0;
      misses_q <= '0;
    end else begin
      state_q <= state_d;
      vaddr_q <= vaddr_d;
      is_write_q <= is_write_d;
      ppn_q <= ppn_d;
      perms_q <= perms_d;
      hit_q <= hit_d;
      fault_q <= fault_d;
      hits_q <= hits_d;
      misses_q <= misses_d;
    end
  assign req_ready = state_q == S_IDLE;
  assign rd_set_index = state_q != S_IDLE ? set_idx : '0;
  assign lru_update_en = state_q == S_LOOKUP && lk_hit;
  assign lru_set_index = lru_update_en ? set_idx : '0;
  assign lru_way = lru_update_en ? lk_way : '0;
  assign wr_en = state_q == S_FILL;
  assign wr_set_index = wr_en ? set_idx : '0;
  assign wr_way = wr_en ? victim : '0;
  assign wr_valid = wr_en;
  assign wr_vpn = wr_en ? vpn : '0;
  assign wr_ppn = wr_en ? ppn_q : '0;
  assign wr_perms = wr_en ? perms_q : '0;
  assign wr_lru_count = {{(LRU_BITS-1){1'b0}}, wr_en};
  assign ptw_req_valid = state_q == S_PTW_REQ;
  assign ptw_req_vpn = ptw_req_valid ? vpn : '0;
  assign resp_valid = state_q == S_RESP;
  assign resp_hit = resp_valid && hit_q;
  assign resp_fault = resp_valid && fault_q;
  assign resp_paddr = resp_valid && !fault_q ? {ppn_q, vaddr_q[PAGE_OFFSET_BITS-1:0]} : '0;
  assign stat_hits = hits_q;
  assign stat_misses = misses_q;
endmodule

// File: tb/tb_tlb_lookup_ctrl.sv
// tb_tlb_lookup_ctrl: storage/walker environment with a spec-level TLB reference and randomized traffic
module tb_tlb_lookup_ctrl;
  logic clk = 1'b0, rst_n = 1'b0;
  always #5 clk = ~clk;
  logic req_valid = 1'b0, req_is_write = 1'b0, resp_ready = 1'b0;
  logic [31:0] req_vaddr = '0;
  logic req_ready, resp_valid, resp_hit, resp_fault;
  logic [31:0] resp_paddr, stat_hits, stat_misses;
  logic [3:0] rd_set_index, wr_set_index, lru_set_index;
  logic [3:0] rd_valid;
  logic [79:0] rd_vpn, rd_ppn;
  logic [7:0] rd_perms;
  logic [15:0] rd_lru_count;
  logic wr_en, wr_valid, lru_update_en, ptw_req_valid;
  logic [1:0] wr_way, wr_perms, lru_way;
  logic [19:0] wr_vpn, wr_ppn, ptw_req_vpn;
  logic [3:0] wr_lru_count;
  logic ptw_req_ready = 1'b0, ptw_resp_valid = 1'b0, ptw_resp_fault = 1'b0;
  logic [19:0] ptw_resp_ppn = '0;
  logic [1:0] ptw_resp_perms = '0;
  int checks = 0, errors = 0, exp_hits = 0, exp_misses = 0;
  int wr_cnt = 0, lru_cnt = 0, both_cnt = 0;
  logic [3:0] last_wr_set, last_lru_set, last_wr_lru;
  logic [1:0] last_wr_way, last_lru_way, last_wr_perms;
  logic [19:0] last_wr_vpn, last_wr_ppn;
  logic last_wr_valid;
  logic st_valid [16][4] = '{default: 1'b0};
  logic [19:0] st_vpn [16][4] = '{default: '0};
  logic [19:0] st_ppn [16][4] = '{default: '0};
  logic [1:0] st_perms [16][4] = '{default: '0};
  logic [3:0] st_lru [16][4] = '{default: '0};

  tlb_lookup_ctrl dut (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready), .req_vaddr(req_vaddr),
    .req_is_write(req_is_write), .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_paddr(resp_paddr),
    .resp_hit(resp_hit), .resp_fault(resp_fault), .rd_set_index(rd_set_index), .rd_valid(rd_valid),
    .rd_vpn(rd_vpn), .rd_ppn(rd_ppn), .rd_perms(rd_perms), .rd_lru_count(rd_lru_count), .wr_en(wr_en),
    .wr_set_index(wr_set_index), .wr_way(wr_way), .wr_valid(wr_valid), .wr_vpn(wr_vpn), .wr_ppn(wr_ppn),
    .wr_perms(wr_perms), .wr_lru_count(wr_lru_count), .lru_update_en(lru_update_en),
    .lru_set_index(lru_set_index), .lru_way(lru_way), .ptw_req_valid(ptw_req_valid),
    .ptw_req_ready(ptw_req_ready), .ptw_req_vpn(ptw_req_vpn), .ptw_resp_valid(ptw_resp_valid),
    .ptw_resp_ppn(ptw_resp_ppn), .ptw_resp_perms(ptw_resp_perms), .ptw_resp_fault(ptw_resp_fault),
    .stat_hits(stat_hits), .stat_misses(stat_misses)
  );

  always_comb
    for (int w = 0; w < 4; w++) begin
      rd_valid[w] = st_valid[rd_set_index][w];
      rd_vpn[w*20 +: 20] = st_vpn[rd_set_index][w];
      rd_ppn[w*20 +: 20] = st_ppn[rd_set_index][w];
      rd_perms[w*2 +: 2] = st_perms[rd_set_index][w];
      rd_lru_count[w*4 +: 4] = st_lru[rd_set_index][w];
    end

  // Storage array behaviour plus event capture for the checks
  always @(posedge clk) begin
    if (wr_en) begin
      st_valid[wr_set_index][wr_way] <= wr_valid;
      st_vpn[wr_set_index][wr_way] <= wr_vpn;
      st_ppn[wr_set_index][wr_way] <= wr_ppn;
      st_perms[wr_set_index][wr_way] <= wr_perms;
      st_lru[wr_set_index][wr_way] <= wr_lru_count;
      wr_cnt <= wr_cnt + 1;
      last_wr_set <= wr_set_index; last_wr_way <= wr_way; last_wr_vpn <= wr_vpn;
      last_wr_ppn <= wr_ppn; last_wr_perms <= wr_perms; last_wr_lru <= wr_lru_count; last_wr_valid <= wr_valid;
    end
    if (lru_update_en) begin
      if (st_lru[lru_set_index][lru_way] != 4'hF) st_lru[lru_set_index][lru_way] <= st_lru[lru_set_index][lru_way] + 4'd1;
      lru_cnt <= lru_cnt + 1;
      last_lru_set <= lru_set_index; last_lru_way <= lru_way;
    end
    if (wr_en && lru_update_en) both_cnt <= both_cnt + 1;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation still running at %0t, required completion", $time);
    $fatal(1, "watchdog");
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  function automatic void page_table(input logic [19:0] vpn, output logic [19:0] ppn, output logic [1:0] perms, output logic flt);
    ppn = vpn ^ 20'hA5C3F;
    perms = vpn[5:4] ^ 2'b11;
    flt = vpn[7:4] == 4'd5;
  endfunction

  task automatic txn(input logic [31:0] va, input logic wr, input logic [19:0] w_ppn, input logic [1:0] w_perms,
                     input logic w_flt, input int rdy_dly, input int hold);
    logic [19:0] vpn, eppn;
    logic [3:0] set;
    logic [1:0] eperm;
    logic eh, ef, ewr;
    logic [31:0] epa;
    int ew, vw, wr0, lru0, n;
    vpn = va[31:12];
    set = vpn[3:0];
    eh = 1'b0; ew = 0; vw = -1;
    wr0 = wr_cnt; lru0 = lru_cnt;
    for (int w = 3; w >= 0; w--)
      if (st_valid[set][w] && st_vpn[set][w] == vpn) begin eh = 1'b1; ew = w; end
    if (eh) begin
      eppn = st_ppn[set][ew]; eperm = st_perms[set][ew]; ef = !eperm[wr]; exp_hits++;
    end else begin
      eppn = w_ppn; eperm = w_perms; ef = w_flt || !eperm[wr]; exp_misses++;
      for (int w = 3; w >= 0; w--) if (!st_valid[set][w]) vw = w;
      if (vw < 0) begin
        vw = 0;
        for (int w = 1; w < 4; w++) if (st_lru[set][w] < st_lru[set][vw]) vw = w;
      end
    end
    ewr = !eh && !w_flt;
    epa = ef ? 32'h0 : {eppn, va[11:0]};
    req_vaddr = va; req_is_write = wr; req_valid = 1'b1;
    checks++; if (req_ready !== 1'b1) begin errors++; $display("FAIL req_ready va=%h: got %b required 1", va, req_ready); end
    tick;
    req_valid = 1'b0; req_vaddr = $urandom; req_is_write = 1'($urandom);
    n = 1;
    if (!eh) begin
      while (ptw_req_valid !== 1'b1 && n < 20) begin tick; n++; end
      checks++;
      if (ptw_req_valid !== 1'b1 || ptw_req_vpn !== vpn) begin
        errors++; $display("FAIL ptw_req va=%h: valid=%b vpn=%h required 1 %h", va, ptw_req_valid, ptw_req_vpn, vpn);
      end
      for (int i = 0; i < rdy_dly; i++) begin
        tick;
        checks++; if (ptw_req_valid !== 1'b1) begin errors++; $display("FAIL ptw_hold va=%h cycle %0d: valid=%b required 1", va, i, ptw_req_valid); end
      end
      ptw_req_ready = 1'b1; tick; ptw_req_ready = 1'b0;
      repeat ($urandom_range(0, 2)) tick;
      ptw_resp_valid = 1'b1; ptw_resp_ppn = w_ppn; ptw_resp_perms = w_perms; ptw_resp_fault = w_flt;
      tick;
      ptw_resp_valid = 1'b0; ptw_resp_ppn = $urandom; ptw_resp_perms = 2'($urandom); ptw_resp_fault = 1'($urandom);
    end
    while (resp_valid !== 1'b1 && n < 40) begin tick; n++; end
    if (eh) begin
      checks++; if (n !== 2) begin errors++; $display("FAIL hit_latency va=%h: %0d cycles required 2", va, n); end
    end
    for (int h = 0; h <= hold; h++) begin
      checks++;
      if (resp_valid !== 1'b1 || resp_paddr !== epa || resp_hit !== eh || resp_fault !== ef) begin
        errors++;
        $display("FAIL resp va=%h wr=%b hold%0d: valid=%b paddr=%h hit=%b fault=%b required 1 %h %b %b",
                 va, wr, h, resp_valid, resp_paddr, resp_hit, resp_fault, epa, eh, ef);
      end
      if (h < hold) tick;
    end
    resp_ready = 1'b1; tick; resp_ready = 1'b0;
    checks++; if (resp_valid !== 1'b0 || req_ready !== 1'b1) begin errors++; $display("FAIL resp_done va=%h: valid=%b ready=%b required 0 1", va, resp_valid, req_ready); end
    checks++; if (wr_cnt - wr0 !== (ewr ? 1 : 0)) begin errors++; $display("FAIL wr_count va=%h: %0d writes required %0d", va, wr_cnt - wr0, ewr ? 1 : 0); end
    if (ewr) begin
      checks++;
      if (last_wr_set !== set || last_wr_way !== 2'(vw) || last_wr_vpn !== vpn || last_wr_ppn !== w_ppn ||
          last_wr_perms !== w_perms || last_wr_lru !== 4'd1 || last_wr_valid !== 1'b1) begin
        errors++;
        $display("FAIL wr_entry va=%h: set=%h way=%0d vpn=%h ppn=%h perms=%b lru=%0d v=%b required %h %0d %h %h %b 1 1",
                 va, last_wr_set, last_wr_way, last_wr_vpn, last_wr_ppn, last_wr_perms, last_wr_lru, last_wr_valid,
                 set, vw, vpn, w_ppn, w_perms);
      end
    end
    checks++; if (lru_cnt - lru0 !== (eh ? 1 : 0)) begin errors++; $display("FAIL lru_count va=%h: %0d pulses required %0d", va, lru_cnt - lru0, eh ? 1 : 0); end
    if (eh) begin
      checks++; if (last_lru_set !== set || last_lru_way !== 2'(ew)) begin errors++; $display("FAIL lru_entry va=%h: set=%h way=%0d required %h %0d", va, last_lru_set, last_lru_way, set, ew); end
    end
    checks++;
    if (stat_hits !== 32'(exp_hits) || stat_misses !== 32'(exp_misses)) begin
      errors++; $display("FAIL stats va=%h: hits=%0d misses=%0d required %0d %0d", va, stat_hits, stat_misses, exp_hits, exp_misses);
    end
  endtask

  task automatic test_reset;
    repeat (2) tick;
    checks++;
    if (req_ready !== 1'b1 || resp_valid !== 1'b0 || resp_paddr !== 32'h0 || resp_hit !== 1'b0 || resp_fault !== 1'b0 ||
        wr_en !== 1'b0 || lru_update_en !== 1'b0 || ptw_req_valid !== 1'b0 || rd_set_index !== 4'h0 ||
        stat_hits !== 32'h0 || stat_misses !== 32'h0) begin
      errors++;
      $display("FAIL reset_outputs: ready=%b rv=%b pa=%h wr=%b lru=%b ptw=%b rd=%h hits=%0d misses=%0d required 1 and all else 0",
               req_ready, resp_valid, resp_paddr, wr_en, lru_update_en, ptw_req_valid, rd_set_index, stat_hits, stat_misses);
    end
    rst_n = 1'b1;
    tick;
  endtask

  task automatic test_cold_miss;
    txn(32'h0000_5ABC, 1'b0, 20'h12345, 2'b01, 1'b0, 0, 0);
    checks++;
    if (last_wr_set !== 4'h5 || last_wr_way !== 2'd0 || last_wr_lru !== 4'd1 || stat_misses !== 32'd1) begin
      errors++; $display("FAIL cold_miss: set=%h way=%0d lru=%0d misses=%0d required 5 0 1 1", last_wr_set, last_wr_way, last_wr_lru, stat_misses);
    end
  endtask

  task automatic test_hit;
    txn(32'h0000_5FFF, 1'b0, 20'h0, 2'b00, 1'b0, 0, 0);
    checks++; if (stat_hits !== 32'd1) begin errors++; $display("FAIL hit_stat: hits=%0d required 1", stat_hits); end
  endtask

  task automatic test_perm_fault;
    txn(32'h0000_5000, 1'b1, 20'h0, 2'b00, 1'b0, 0, 1);
  endtask

  task automatic test_eviction;
    for (int i = 0; i < 4; i++) txn({8'h0, 4'(i), 4'h3, 12'h111}, 1'b0, 20'h00100 + 20'(i), 2'b11, 1'b0, 0, 0);
    txn(32'h0001_3000, 1'b0, 20'h0, 2'b00, 1'b0, 0, 0);
    for (int i = 0; i < 4; i++) txn({8'h0, 4'(i), 4'h3, 12'h222}, 1'b1, 20'h0, 2'b00, 1'b0, 0, 0);
    txn(32'h0004_3008, 1'b0, 20'h00777, 2'b11, 1'b0, 0, 0);
    checks++; if (last_wr_way !== 2'd0 || last_wr_set !== 4'h3) begin errors++; $display("FAIL evict_way: set=%h way=%0d required 3 0", last_wr_set, last_wr_way); end
  endtask

  task automatic test_walk_fault;
    txn(32'h0007_7123, 1'b0, 20'h0ABCD, 2'b11, 1'b1, 5, 3);
  endtask

  task automatic test_random;
    logic [19:0] vpn, ppn;
    logic [1:0] perms;
    logic flt;
    for (int i = 0; i < 40; i++) begin
      vpn = {12'h0, 4'($urandom_range(0, 5)), 4'($urandom_range(1, 2))};
      page_table(vpn, ppn, perms, flt);
      txn({vpn, 12'($urandom)}, 1'($urandom), ppn, perms, flt, $urandom_range(0, 2), $urandom_range(0, 2));
    end
  endtask

  task automatic test_reset_mid_walk;
    int wr0;
    req_vaddr = 32'h0008_8000; req_is_write = 1'b0; req_valid = 1'b1;
    tick; req_valid = 1'b0;
    tick;
    checks++; if (ptw_req_valid !== 1'b1) begin errors++; $display("FAIL midwalk_req: ptw_req_valid=%b required 1", ptw_req_valid); end
    ptw_req_ready = 1'b1; tick; ptw_req_ready = 1'b0;
    wr0 = wr_cnt;
    rst_n = 1'b0;
    #1;
    checks++;
    if (req_ready !== 1'b1 || ptw_req_valid !== 1'b0 || resp_valid !== 1'b0 || rd_set_index !== 4'h0 ||
        stat_hits !== 32'h0 || stat_misses !== 32'h0) begin
      errors++;
      $display("FAIL midwalk_reset: ready=%b ptw=%b rv=%b rd=%h hits=%0d misses=%0d required 1 0 0 0 0 0",
               req_ready, ptw_req_valid, resp_valid, rd_set_index, stat_hits, stat_misses);
    end
    exp_hits = 0; exp_misses = 0;
    tick; rst_n = 1'b1; tick;
    ptw_resp_valid = 1'b1; ptw_resp_ppn = 20'h5555; ptw_resp_perms = 2'b11; ptw_resp_fault = 1'b0;
    tick; ptw_resp_valid = 1'b0;
    repeat (3) tick;
    checks++;
    if (wr_cnt !== wr0 || req_ready !== 1'b1 || resp_valid !== 1'b0) begin
      errors++; $display("FAIL midwalk_after: writes=%0d ready=%b rv=%b required %0d 1 0", wr_cnt, req_ready, resp_valid, wr0);
    end
    txn(32'h0000_5123, 1'b0, 20'h0, 2'b00, 1'b0, 0, 0);
  endtask

  initial begin
    test_reset;
    test_cold_miss;
    test_hit;
    test_perm_fault;
    test_eviction;
    test_walk_fault;
    test_random;
    test_reset_mid_walk;
    checks++; if (both_cnt !== 0) begin errors++; $display("FAIL wr_lru_overlap: %0d cycles required 0", both_cnt); end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
